// File: rtl/windower_frame_sequencer.sv
// Round-robin frame scheduler that feeds one shared windower from NO_SRC FWFT frame buffers.
// Streams FRAME_BEATS contiguous beats per grant, then idles so the windower can finish its autorun.
module windower_frame_sequencer #(
  parameter int NO_SRC        = 4,
  parameter int NO_CH         = 2,
  parameter int LOG2_IMG_SIZE = 10,
  parameter int SER_CYC       = 1,
  parameter int WINDOW_SIZE   = 3,
  parameter int DRAIN_CYC     = SER_CYC * ((WINDOW_SIZE - 1) / 2) + 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NO_SRC-1:0]           frame_rdy,
  input  logic [NO_SRC*NO_CH-1:0]     src_data,
  output logic [NO_SRC-1:0]           src_rd,
  output logic                        win_vld_in,
  output logic [NO_CH-1:0]            win_data_in,
  output logic [$clog2(NO_SRC)-1:0]   grant_idx,
  output logic                        busy,
  output logic                        frame_done,
  output logic [15:0]                 frame_cnt,
  output logic [1:0]                  state_dbg
);

  localparam int GW          = $clog2(NO_SRC);
  localparam int FRAME_BEATS = (2 ** LOG2_IMG_SIZE) * SER_CYC;
  localparam int BW          = LOG2_IMG_SIZE + $clog2(SER_CYC) + 1;
  localparam int DW          = $clog2(DRAIN_CYC + 1);

  localparam logic [BW-1:0] LAST_BEAT  = BW'(FRAME_BEATS - 1);
  localparam logic [DW-1:0] LAST_DRAIN = DW'(DRAIN_CYC - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARB    = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]       state;
  logic [BW-1:0]    beat_cnt;
  logic [DW-1:0]    drain_cnt;
  logic             arb_found;
  logic [GW-1:0]    arb_idx;
  logic [NO_CH-1:0] sel_data;

  // Handshake: src_rd is a pop strobe; the FWFT head beat on src_data is consumed in the
  // same cycle src_rd is high, and appears on win_data_in/win_vld_in one cycle later.

  // Rotating priority: distance 0 is the source just after the last grant.
  always_comb begin
    int best_d;
    int d;
    best_d    = NO_SRC;
    d         = 0;
    arb_idx   = grant_idx;
    arb_found = |frame_rdy;
    for (int i = 0; i < NO_SRC; i++) begin
      if (frame_rdy[i]) begin
        d = (i + 2 * NO_SRC - 1 - int'(grant_idx)) % NO_SRC;
        if (d < best_d) begin
          best_d  = d;
          arb_idx = GW'(i);
        end
      end
    end
  end

  always_comb begin
    src_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NO_SRC; i++) begin
      if (grant_idx == GW'(i)) begin
        sel_data  = src_data[i*NO_CH +: NO_CH];
        src_rd[i] = (state == S_STREAM);
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      win_vld_in  <= 1'b0;
      win_data_in <= '0;
      grant_idx   <= GW'(NO_SRC - 1);
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      beat_cnt    <= '0;
      drain_cnt   <= '0;
    end else begin
      win_vld_in <= (state == S_STREAM);
      frame_done <= 1'b0;
      if (state == S_STREAM) begin
        win_data_in <= sel_data;
      end
      case (state)
        S_IDLE: begin
          if (|frame_rdy) state <= S_ARB;
        end
        S_ARB: begin
          if (arb_found) begin
            grant_idx <= arb_idx;
            beat_cnt  <= '0;
            state     <= S_STREAM;
          end else begin
            state <= S_IDLE;
          end
        end
        S_STREAM: begin
          // frame_done and frame_cnt land together with the last registered beat.
          if (beat_cnt == LAST_BEAT) begin
            state      <= S_DRAIN;
            drain_cnt  <= '0;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
          end else begin
            beat_cnt <= beat_cnt + BW'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == LAST_DRAIN) state <= S_IDLE;
          else drain_cnt <= drain_cnt + DW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_windower_frame_sequencer.sv
// Directed bench for windower_frame_sequencer: FWFT source models, data scoreboard,
// frame-gap monitor, a grant table and hand-written reset/withdraw sequences.
module tb_windower_frame_sequencer;

  localparam int NO_SRC        = 4;
  localparam int NO_CH         = 4;
  localparam int LOG2_IMG_SIZE = 3;
  localparam int SER_CYC       = 2;
  localparam int WINDOW_SIZE   = 3;
  localparam int FRAME_BEATS   = 16;
  localparam int DRAIN_CYC     = 4;
  localparam int MIN_GAP       = DRAIN_CYC + 2;

  logic                    clk;
  logic                    rst;
  logic [NO_SRC-1:0]       frame_rdy;
  logic [NO_SRC*NO_CH-1:0] src_data;
  logic [NO_SRC-1:0]       src_rd;
  logic                    win_vld_in;
  logic [NO_CH-1:0]        win_data_in;
  logic [1:0]              grant_idx;
  logic                    busy;
  logic                    frame_done;
  logic [15:0]             frame_cnt;
  logic [1:0]              state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  windower_frame_sequencer #(
    .NO_SRC(NO_SRC), .NO_CH(NO_CH), .LOG2_IMG_SIZE(LOG2_IMG_SIZE),
    .SER_CYC(SER_CYC), .WINDOW_SIZE(WINDOW_SIZE)
  ) dut (
    .clk(clk), .rst(rst), .frame_rdy(frame_rdy), .src_data(src_data),
    .src_rd(src_rd), .win_vld_in(win_vld_in), .win_data_in(win_data_in),
    .grant_idx(grant_idx), .busy(busy), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // FWFT sources: source i presents (pops + 4*i) mod 16, advancing on each pop.
  int ptr[NO_SRC] = '{default: 0};
  always_comb begin
    src_data = '0;
    for (int i = 0; i < NO_SRC; i++) src_data[i*NO_CH +: NO_CH] = NO_CH'(ptr[i] + 4 * i);
  end

  // scoreboard: every popped beat must appear on win_* in order
  logic [NO_CH-1:0] exp_q[$];
  always @(posedge clk) begin
    if (rst) exp_q.delete();
    else begin
      for (int i = 0; i < NO_SRC; i++)
        if (src_rd[i]) exp_q.push_back(src_data[i*NO_CH +: NO_CH]);
    end
    for (int i = 0; i < NO_SRC; i++)
      if (src_rd[i]) ptr[i] <= ptr[i] + 1;
  end

  int  low_run = 0;
  bit  seen    = 0;
  always @(negedge clk) begin
    logic [NO_CH-1:0] e;
    if (rst) begin
      seen    = 0;
      low_run = 0;
    end else begin
      chk($countones(src_rd) <= 1, "src_rd_onehot", 32'(src_rd), 1);
      if (win_vld_in) begin
        chk(exp_q.size() != 0, "sb_underflow", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk(win_data_in == e, "sb_data", 32'(win_data_in), 32'(e));
        end
        if (seen && low_run > 0) chk(low_run >= MIN_GAP, "frame_gap", low_run, MIN_GAP);
        seen    = 1;
        low_run = 0;
      end else begin
        low_run++;
      end
    end
  end

  // driver tasks
  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(!busy, {name, "_idle_timeout"}, 32'(busy), 0);
  endtask

  task automatic run_frame(input logic [1:0] exp_grant, input logic [15:0] exp_cnt,
                           input int exp_last, input string name);
    int n   = 0;
    int bad = 0;
    logic [NO_SRC-1:0] exp_rd;
    exp_rd = NO_SRC'(1) << exp_grant;
    while (src_rd == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(n < 40, {name, "_start_timeout"}, n, 40);
    if (n >= 40) return;
    for (int b = 0; b < FRAME_BEATS; b++) begin
      if (src_rd != exp_rd) bad++;
      if (b == 0) chk(!win_vld_in, {name, "_latency0"}, 32'(win_vld_in), 0);
      if (b == 1) chk(win_vld_in, {name, "_latency1"}, 32'(win_vld_in), 1);
      @(negedge clk);
    end
    chk(bad == 0, {name, "_src_rd_pattern"}, bad, 0);
    chk(src_rd == '0, {name, "_rd_drop"}, 32'(src_rd), 0);
    chk(frame_done && win_vld_in, {name, "_done_last_beat"}, {frame_done, win_vld_in}, 3);
    chk(frame_cnt == exp_cnt, {name, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
    chk(grant_idx == exp_grant, {name, "_grant"}, 32'(grant_idx), 32'(exp_grant));
    chk(state_dbg == 2'd3, {name, "_state_drain"}, 32'(state_dbg), 3);
    if (exp_last >= 0) chk(win_data_in == NO_CH'(exp_last), {name, "_last_data"}, 32'(win_data_in), exp_last);
    @(negedge clk);
    chk(!frame_done && !win_vld_in, {name, "_after_done"}, {frame_done, win_vld_in}, 0);
  endtask

  typedef struct {
    logic [3:0]  rdy;
    logic [1:0]  grant;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int bad;
    int n;
    vecs[0] = '{4'b1111, 2'd1, 16'd2};
    vecs[1] = '{4'b1111, 2'd2, 16'd3};
    vecs[2] = '{4'b1111, 2'd3, 16'd4};
    vecs[3] = '{4'b1111, 2'd0, 16'd5};
    vecs[4] = '{4'b1111, 2'd1, 16'd6};
    vecs[5] = '{4'b1010, 2'd3, 16'd7};
    vecs[6] = '{4'b1010, 2'd1, 16'd8};
    vecs[7] = '{4'b0100, 2'd2, 16'd9};

    rst       = 1'b1;
    frame_rdy = '0;
    repeat (3) @(negedge clk);
    chk(src_rd == '0, "rst_src_rd", 32'(src_rd), 0);
    chk(!win_vld_in, "rst_vld", 32'(win_vld_in), 0);
    chk(win_data_in == '0, "rst_data", 32'(win_data_in), 0);
    chk(grant_idx == 2'd3, "rst_grant", 32'(grant_idx), 3);
    chk(!busy, "rst_busy", 32'(busy), 0);
    chk(!frame_done, "rst_done", 32'(frame_done), 0);
    chk(frame_cnt == 16'd0, "rst_cnt", 32'(frame_cnt), 0);
    chk(state_dbg == 2'd0, "rst_state", 32'(state_dbg), 0);
    rst = 1'b0;
    @(negedge clk);

    // single source ramp
    frame_rdy = 4'b0001;
    run_frame(2'd0, 16'd1, 15, "t1");

    // round robin and skipping
    for (int i = 0; i < 8; i++) begin
      frame_rdy = vecs[i].rdy;
      run_frame(vecs[i].grant, vecs[i].cnt, -1, $sformatf("vec%0d", i));
    end
    frame_rdy = '0;
    wait_idle("table");

    // request withdrawn before arbitration
    frame_rdy = 4'b0001;
    @(negedge clk);
    chk(state_dbg == 2'd1 && busy, "t5_arb", 32'(state_dbg), 1);
    frame_rdy = '0;
    @(negedge clk);
    chk(state_dbg == 2'd0, "t5_back_idle", 32'(state_dbg), 0);
    chk(grant_idx == 2'd2, "t5_grant_kept", 32'(grant_idx), 2);
    bad = 0;
    repeat (4) begin
      if (src_rd != '0 || busy) bad++;
      @(negedge clk);
    end
    chk(bad == 0, "t5_no_rd", bad, 0);

    // reset mid-frame
    frame_rdy = 4'b0001;
    n = 0;
    while (src_rd == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(n < 40, "t4_start_timeout", n, 40);
    repeat (5) @(negedge clk);
    chk(src_rd == 4'b0001, "t4_beat5_rd", 32'(src_rd), 1);
    rst = 1'b1;
    @(negedge clk);
    chk(src_rd == '0 && !win_vld_in && win_data_in == '0, "t4_outputs",
        {src_rd, win_vld_in, win_data_in}, 0);
    chk(grant_idx == 2'd3, "t4_grant", 32'(grant_idx), 3);
    chk(!busy && !frame_done, "t4_busy_done", {busy, frame_done}, 0);
    chk(frame_cnt == 16'd0, "t4_cnt", 32'(frame_cnt), 0);
    chk(state_dbg == 2'd0, "t4_state", 32'(state_dbg), 0);
    rst = 1'b0;
    run_frame(2'd0, 16'd1, -1, "t4_restart");
    frame_rdy = '0;
    wait_idle("t4");
    chk(exp_q.size() == 0, "sb_leftover", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
